clause_load_controller: RTL and testbench
=========================================

CLAUSE_LOAD_CONTROLLER -- requirements
Module: clause_load_controller

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_CLAUSES, default 4: number of clause registers sequenced, identifiers 1..NUMBER_OF_CLAUSES.
REQ-002 The block SHALL have parameter MAX_BIT_WIDTH_OF_CLAUSES_INDEX, default 3: index width, holding 0..NUMBER_OF_CLAUSES.
REQ-003 The block SHALL have parameter CLAUSE_WORD_WIDTH, default 6: packed clause coefficient word width.
REQ-004 The block SHALL have port in_clk, input, 1: sole clock, rising edge.
REQ-005 The block SHALL have port in_reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_start, input, 1: start-load request pulse.
REQ-007 The block SHALL have port in_abort, input, 1: abort current load.
REQ-008 The block SHALL have port in_coeff_valid, input, 1: source word valid.
REQ-009 The block SHALL have port in_coeff_data, input, CLAUSE_WORD_WIDTH: source clause word.
REQ-010 The block SHALL have port out_coeff_ready, output, 1: controller accepts word.
REQ-011 The block SHALL have port out_clause_coefficients, output, CLAUSE_WORD_WIDTH: word broadcast to all clause registers.
REQ-012 The block SHALL have port out_clause_index, output, MAX_BIT_WIDTH_OF_CLAUSES_INDEX: target identifier; 0 means no write.
REQ-013 The block SHALL have port out_clause_clear, output, 1: synchronous clear broadcast to clause registers.
REQ-014 The block SHALL have port out_busy, output, 1: load in progress.
REQ-015 The block SHALL have port out_done, output, 1: single-cycle load-complete pulse.
REQ-016 The block SHALL have port out_loaded_count, output, MAX_BIT_WIDTH_OF_CLAUSES_INDEX: clauses written in current/last load.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, LOAD and DONE.
REQ-018 IDLE: in_start=1 SHALL transition to CLEAR (macro defined) or LOAD (macro undefined), clear out_loaded_count to 0 and set the internal target counter to 1.
REQ-019 LOAD: out_coeff_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-020 Beat accepted at edge N (valid and ready): from N until N+1, out_clause_coefficients SHALL equal the accepted word and out_clause_index SHALL equal the target counter, giving exactly one register write at edge N+1.
REQ-021 Each accepted beat SHALL increment the target counter and out_loaded_count by 1.
REQ-022 out_clause_index SHALL be 0 in every cycle not following an accepted beat; out_clause_coefficients SHALL hold its last value.
REQ-023 in_coeff_valid=0 in LOAD SHALL stall with no write, indefinitely, without timeout.
REQ-024 Acceptance of beat number NUMBER_OF_CLAUSES SHALL transition to DONE; no further beat SHALL be accepted.
REQ-025 DONE SHALL last one cycle with out_done=1, coinciding with the final write's index presentation, then SHALL return to IDLE.
REQ-026 out_busy SHALL be 1 in CLEAR, LOAD and DONE, and 0 in IDLE.
REQ-027 in_start outside IDLE SHALL be ignored.
REQ-028 in_abort=1 in any state SHALL transition to IDLE at the next edge, force out_clause_index to 0, suppress out_done, and retain out_loaded_count.
REQ-029 in_abort and in_start asserted together in IDLE SHALL leave the FSM in IDLE (abort wins).
REQ-030 Already-written clause registers SHALL keep their contents after abort.

Reset
REQ-031 On in_reset_n=0, the block SHALL enter IDLE immediately and asynchronously.
REQ-032 During reset, out_clause_index, out_clause_coefficients, out_loaded_count, out_coeff_ready, out_busy, out_done and out_clause_clear SHALL all be 0.
REQ-033 Reset mid-load SHALL discard the load; the first edge after deassertion SHALL evaluate as IDLE.

Configuration
REQ-034 With macro CLAUSE_LOAD_CLEAR_EN defined, the FSM SHALL spend one cycle in CLEAR with out_clause_clear=1, then enter LOAD, so all clause registers zero before the first write.
REQ-035 With CLAUSE_LOAD_CLEAR_EN undefined, the CLEAR state SHALL not exist, out_clause_clear SHALL be tied 0, and start SHALL go directly to LOAD.

Verification
REQ-036 The bench SHALL cover: NUMBER_OF_CLAUSES=4, start, then valid held 1 with words 0x11,0x22,0x33,0x04 -> out_clause_index sequence 1,2,3,4 on consecutive cycles, out_done high with index 4, then index 0 and out_busy 0.
REQ-037 The bench SHALL cover: valid toggled 1,0,0,1 during load -> exactly one write per valid beat, index 0 during gaps, out_loaded_count steps 1 then 2.
REQ-038 The bench SHALL cover: in_abort after 2 beats -> IDLE next cycle, out_loaded_count=2, no out_done, and a following start reloads from index 1.
REQ-039 The bench SHALL cover: in_reset_n low mid-load for 1 cycle, asynchronous to the clock edge -> all outputs 0 immediately, IDLE after release.
REQ-040 The bench SHALL cover: with CLAUSE_LOAD_CLEAR_EN, start -> out_clause_clear=1 for exactly one cycle and out_coeff_ready=0 in that cycle, then LOAD; without the macro, out_coeff_ready=1 the cycle after start.
REQ-041 The bench SHALL cover: in_start pulsed during LOAD, and start+abort together in IDLE -> no state change and counters unaffected.

Source files
------------

// File: rtl/clause_load_controller.sv
// ---------------------------------------------------------------------------
// clause_load_controller
//
// Sequences a burst of clause coefficient words from a valid/ready source into
// NUMBER_OF_CLAUSES clause registers. The registers share one broadcast word
// bus. Each register is addressed by a 1-based identifier on out_clause_index,
// and 0 on that bus means "no write this cycle".
//
// Optional feature (macro CLAUSE_LOAD_CLEAR_EN):
//   If defined, a start request first spends one cycle in CLEAR with
//   out_clause_clear=1, so every clause register is zeroed before the first
//   write. If undefined, CLEAR does not exist and out_clause_clear is tied 0.
//
// Handshake:
//   A beat transfers at a rising edge where in_coeff_valid && out_coeff_ready.
//   out_coeff_ready is high only in LOAD, and it is masked by in_abort, so a
//   beat offered together with an abort is never taken.
//   A beat accepted at edge N is presented on out_clause_coefficients and
//   out_clause_index from N to N+1, which gives exactly one register write
//   at edge N+1.
//
// Ports:
//   in_clk                   clock, rising edge
//   in_reset_n               asynchronous active-low reset
//   in_start                 start-load request (honoured in IDLE only)
//   in_abort                 abort the load; returns to IDLE at the next edge
//   in_coeff_valid/_data     source word stream
//   out_coeff_ready          controller accepts a word this cycle
//   out_clause_coefficients  word broadcast to all clause registers
//   out_clause_index         target clause identifier, 0 = no write
//   out_clause_clear         synchronous clear broadcast to the clause registers
//   out_busy                 a load is in progress (CLEAR/LOAD/DONE)
//   out_done                 single-cycle load-complete pulse
//   out_loaded_count         clauses written in the current or last load
//   out_fsm_state            debug view of the FSM state register
// ---------------------------------------------------------------------------
module clause_load_controller #(
  parameter int NUMBER_OF_CLAUSES              = 4,
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
  parameter int CLAUSE_WORD_WIDTH              = 6
) (
  input  logic                                      in_clk,
  input  logic                                      in_reset_n,
  input  logic                                      in_start,
  input  logic                                      in_abort,
  input  logic                                      in_coeff_valid,
  input  logic [CLAUSE_WORD_WIDTH-1:0]              in_coeff_data,
  output logic                                      out_coeff_ready,
  output logic [CLAUSE_WORD_WIDTH-1:0]              out_clause_coefficients,
  output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
  output logic                                      out_clause_clear,
  output logic                                      out_busy,
  output logic                                      out_done,
  output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_loaded_count,
  output logic [1:0]                                out_fsm_state
);

  localparam int IW = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int CW = CLAUSE_WORD_WIDTH;
  localparam logic [IW-1:0] LAST_ID = IW'(NUMBER_OF_CLAUSES);
  localparam logic [IW-1:0] ONE     = IW'(1);

`ifdef CLAUSE_LOAD_CLEAR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, LOAD = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd2, DONE = 2'd3} state_t;
`endif

  state_t          state_q, state_d;
  logic [IW-1:0]   target_q, target_d;   // identifier the next accepted beat writes
  logic [IW-1:0]   count_q, count_d;
  logic [IW-1:0]   index_q, index_d;
  logic [CW-1:0]   coeff_q, coeff_d;
  logic            accept;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      count_q  <= '0;
      index_q  <= '0;
      coeff_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      index_q  <= index_d;
      coeff_q  <= coeff_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    count_d          = count_q;
    index_d          = '0;        // index is only non-zero right after a beat
    coeff_d          = coeff_q;   // broadcast word holds its last value
    accept           = 1'b0;
    out_coeff_ready  = 1'b0;
    out_busy         = 1'b1;
    out_done         = 1'b0;
    out_clause_clear = 1'b0;

    case (state_q)
      IDLE: begin
        out_busy = 1'b0;
        // Abort has priority over start.
        if (in_start && !in_abort) begin
`ifdef CLAUSE_LOAD_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = LOAD;
`endif
          count_d  = '0;
          target_d = ONE;
        end
      end
`ifdef CLAUSE_LOAD_CLEAR_EN
      CLEAR: begin
        out_clause_clear = 1'b1;
        state_d          = LOAD;
      end
`endif
      LOAD: begin
        out_coeff_ready = !in_abort;
        accept          = in_coeff_valid && !in_abort;
        if (accept) begin
          index_d  = target_q;
          coeff_d  = in_coeff_data;
          target_d = target_q + ONE;
          count_d  = count_q + ONE;
          if (target_q == LAST_ID) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // This cycle is also the one presenting the final write's index.
        out_done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort returns to IDLE from any state. No beat is accepted, so the index
    // goes to 0 and the loaded count is kept.
    if (in_abort) begin
      state_d = IDLE;
    end
  end

  assign out_clause_index        = index_q;
  assign out_clause_coefficients = coeff_q;
  assign out_loaded_count        = count_q;
  assign out_fsm_state           = state_q;

endmodule

// File: tb/tb_clause_load_controller.sv
module tb_clause_load_controller;

  localparam int N  = 4;
  localparam int IW = 3;
  localparam int CW = 6;
`ifdef CLAUSE_LOAD_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, abort, valid;
  logic [CW-1:0] data;
  logic          ready, clear, busy, done;
  logic [CW-1:0] coeff;
  logic [IW-1:0] index, count;
  logic [1:0]    fsm_state;

  clause_load_controller #(
    .NUMBER_OF_CLAUSES(N),
    .MAX_BIT_WIDTH_OF_CLAUSES_INDEX(IW),
    .CLAUSE_WORD_WIDTH(CW)
  ) dut (
    .in_clk(clk),
    .in_reset_n(rst_n),
    .in_start(start),
    .in_abort(abort),
    .in_coeff_valid(valid),
    .in_coeff_data(data),
    .out_coeff_ready(ready),
    .out_clause_coefficients(coeff),
    .out_clause_index(index),
    .out_clause_clear(clear),
    .out_busy(busy),
    .out_done(done),
    .out_loaded_count(count),
    .out_fsm_state(fsm_state)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboard: each accepted beat, as {identifier, word}, in acceptance order.
  logic [IW+CW-1:0] exp_q[$];

  // Clause registers as the DUT's broadcast bus writes them, and as the model
  // says they should be.
  logic [CW-1:0] dut_regs[N+1];
  logic [CW-1:0] exp_regs[N+1];

  always @(posedge clk) begin
    if (clear) begin
      foreach (dut_regs[i]) dut_regs[i] <= '0;
    end
    if (index != '0 && int'(index) <= N) begin
      dut_regs[index] <= coeff;
    end
  end

  // ---------------- reference model ----------------
  // The load is described as activity flags and counts of clauses written.
  bit            m_clearing, m_loading, m_done;
  int            m_count, m_next, m_idx;
  logic [CW-1:0] m_coeff;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    // A write still being presented when reset hits never happens.
    if (m_idx != 0 && exp_q.size() > 0) void'(exp_q.pop_back());
    m_clearing = 0; m_loading = 0; m_done = 0;
    m_count = 0; m_next = 0; m_idx = 0; m_coeff = '0;
  endtask

  // Advance the model across one rising edge using the inputs applied now.
  task automatic model_edge();
    bit            acc;
    logic [IW-1:0] id;
    acc = m_loading && !abort && valid;
    if (m_idx != 0) exp_regs[m_idx] = m_coeff;
    if (m_clearing) foreach (exp_regs[i]) exp_regs[i] = '0;
    if (acc) begin
      m_idx   = m_next;
      m_coeff = data;
      m_count = m_count + 1;
      m_next  = m_next + 1;
      id      = IW'(m_idx);
      exp_q.push_back({id, data});
    end else begin
      m_idx = 0;
    end
    if (abort) begin
      m_clearing = 0; m_loading = 0; m_done = 0;
    end else if (!m_clearing && !m_loading && !m_done) begin
      if (start) begin
        m_clearing = CLR;
        m_loading  = !CLR;
        m_count    = 0;
        m_next     = 1;
      end
    end else if (m_clearing) begin
      m_clearing = 0;
      m_loading  = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (acc && m_count == N) begin
      m_loading = 0;
      m_done    = 1;
    end
  endtask

  task automatic check_outputs();
    logic [IW+CW-1:0] e;
    check_eq("busy",  busy,  m_clearing || m_loading || m_done);
    check_eq("ready", ready, m_loading && !abort);
    check_eq("done",  done,  m_done);
    check_eq("clear", clear, m_clearing);
    check_eq("index", index, m_idx);
    check_eq("coeff", coeff, m_coeff);
    check_eq("loaded_count", count, m_count);
    if (index != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("write_unexpected", index, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("write_stream", {index, coeff}, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: apply inputs, check at the falling edge,
  // then let the model take the next rising edge.
  task automatic cycle(input bit st, input bit ab, input bit v, input logic [CW-1:0] d);
    start = st; abort = ab; valid = v; data = d;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0);
  endtask

  task automatic begin_load();
    cycle(1, 0, 0, '0);
    if (CLR) cycle(0, 0, 0, '0);
  endtask

  task automatic beat(input logic [CW-1:0] d);
    cycle(0, 0, 1, d);
  endtask

  // Reset pulse placed between clock edges; outputs must drop at once.
  task automatic async_reset_pulse();
    start = 0; abort = 0; valid = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    foreach (dut_regs[i]) begin dut_regs[i] = '0; exp_regs[i] = '0; end
    rst_n = 1'b0; start = 0; abort = 0; valid = 0; data = '0;
    model_reset();
    #3 check_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full load with the valid line held high.
    begin_load();
    beat(6'h11); beat(6'h22); beat(6'h33); beat(6'h04);
    idle(3);
    check_eq("s1_reg1", dut_regs[1], 6'h11);
    check_eq("s1_reg2", dut_regs[2], 6'h22);
    check_eq("s1_reg3", dut_regs[3], 6'h33);
    check_eq("s1_reg4", dut_regs[4], 6'h04);
    check_eq("s1_count", count, 4);

    // Valid goes 1,0,0,1 and then the load finishes.
    begin_load();
    beat(CW'($urandom)); idle(2); beat(CW'($urandom));
    check_eq("s2_count_after_gap", count, 2);
    beat(CW'($urandom)); beat(CW'($urandom));
    idle(2);

    // Abort after two beats, then reload from identifier 1.
    begin_load();
    beat(CW'($urandom)); beat(CW'($urandom));
    cycle(0, 1, 0, '0);
    idle(2);
    check_eq("s3_count_kept", count, 2);
    check_eq("s3_idle_busy", busy, 0);
    begin_load();
    beat(6'h2a); beat(CW'($urandom)); beat(CW'($urandom)); beat(CW'($urandom));
    idle(2);
    check_eq("s3_reload_reg1", dut_regs[1], 6'h2a);

    // Asynchronous reset in the middle of a load.
    begin_load();
    beat(CW'($urandom));
    async_reset_pulse();
    idle(2);
    begin_load();
    for (int i = 0; i < N; i++) beat(CW'($urandom));
    idle(2);

    // Start during LOAD is ignored. Start together with abort in IDLE does nothing.
    begin_load();
    beat(CW'($urandom));
    cycle(1, 0, 1, CW'($urandom));
    cycle(1, 0, 0, '0);
    beat(CW'($urandom)); beat(CW'($urandom));
    idle(2);
    cycle(1, 1, 0, '0);
    idle(2);
    check_eq("s5_count_kept", count, 4);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 1) == 1, CW'($urandom));
    end
    idle(4);

    // ---------------- final report ----------------
    for (int i = 1; i <= N; i++) check_eq($sformatf("reg%0d", i), dut_regs[i], exp_regs[i]);
    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
